// File: rtl/gb_cpu_opcode_sequencer.sv
// Opcode fetch/decode sequencer for a Game Boy style CPU: collects opcode, CB sub-opcode
// and immediates byte by byte, then tracks execute M-cycles with a watchdog.
module gb_cpu_opcode_sequencer #(
  parameter int MAX_MCYCLES = 6,
  parameter bit CB_ENABLE   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        exec_done,
  input  logic        wake,
  output logic [2:0]  state,
  output logic        fetch_req,
  output logic        pc_inc,
  output logic [7:0]  opcode_q,
  output logic        cb_q,
  output logic [15:0] imm_q,
  output logic        instr_valid,
  output logic [2:0]  mcycle_idx,
  output logic        timeout,
  output logic        locked
);

  typedef enum logic [2:0] {
    READ_OPCODE    = 3'd0,
    READ_CB_OPCODE = 3'd1,
    READ_R8        = 3'd2,
    READ_R16_BYTE0 = 3'd3,
    READ_R16_BYTE1 = 3'd4,
    EXECUTE        = 3'd5,
    HALTED         = 3'd6,
    LOCKED         = 3'd7
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(MAX_MCYCLES - 1);

  state_t      cur, nxt;
  logic [7:0]  opcode_n;
  logic        cb_n;
  logic [15:0] imm_n;
  logic        valid_n;
  logic [2:0]  idx_n;

  function automatic logic is_imm8(input logic [7:0] op);
    return (op[7:6] == 2'b00 && op[2:0] == 3'b110) ||
           (op[7:5] == 3'b001 && op[2:0] == 3'b000) ||
           (op[7:6] == 2'b11 && op[2:0] == 3'b110) ||
           op == 8'h18 || op == 8'h10 || op == 8'hE0 ||
           op == 8'hF0 || op == 8'hE8 || op == 8'hF8;
  endfunction

  function automatic logic is_imm16(input logic [7:0] op);
    return (op[7:6] == 2'b00 && op[3:0] == 4'b0001) ||
           op == 8'h08 || op == 8'hC2 || op == 8'hCA || op == 8'hD2 ||
           op == 8'hDA || op == 8'hC3 || op == 8'hC4 || op == 8'hCC ||
           op == 8'hD4 || op == 8'hDC || op == 8'hCD || op == 8'hEA ||
           op == 8'hFA;
  endfunction

  function automatic logic is_lock(input logic [7:0] op);
    return op == 8'hD3 || op == 8'hDB || op == 8'hDD || op == 8'hE3 ||
           op == 8'hE4 || op == 8'hEB || op == 8'hEC || op == 8'hED ||
           op == 8'hF4 || op == 8'hFC || op == 8'hFD;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= READ_OPCODE;
      opcode_q    <= 8'h00;
      cb_q        <= 1'b0;
      imm_q       <= 16'h0000;
      instr_valid <= 1'b0;
      mcycle_idx  <= 3'd0;
    end else begin
      cur         <= nxt;
      opcode_q    <= opcode_n;
      cb_q        <= cb_n;
      imm_q       <= imm_n;
      instr_valid <= valid_n;
      mcycle_idx  <= idx_n;
    end
  end

  // Fetch states only move on a valid byte; idx_n defaults to 0 so EXECUTE is entered at 0.
  always_comb begin
    nxt      = cur;
    opcode_n = opcode_q;
    cb_n     = cb_q;
    imm_n    = imm_q;
    valid_n  = 1'b0;
    idx_n    = 3'd0;
    case (cur)
      READ_OPCODE: if (byte_valid) begin
        opcode_n = byte_data;
        cb_n     = 1'b0;
        imm_n    = 16'h0000;
        if (byte_data == 8'hCB)    nxt = CB_ENABLE ? READ_CB_OPCODE : LOCKED;
        else if (is_lock(byte_data))  nxt = LOCKED;
        else if (is_imm16(byte_data)) nxt = READ_R16_BYTE0;
        else if (is_imm8(byte_data))  nxt = READ_R8;
        else begin
          nxt     = (byte_data == 8'h76) ? HALTED : EXECUTE;
          valid_n = 1'b1;
        end
      end
      READ_CB_OPCODE: if (byte_valid) begin
        opcode_n = byte_data;
        cb_n     = 1'b1;
        valid_n  = 1'b1;
        nxt      = EXECUTE;
      end
      READ_R8: if (byte_valid) begin
        imm_n   = {8'h00, byte_data};
        valid_n = 1'b1;
        nxt     = EXECUTE;
      end
      READ_R16_BYTE0: if (byte_valid) begin
        imm_n = {imm_q[15:8], byte_data};
        nxt   = READ_R16_BYTE1;
      end
      READ_R16_BYTE1: if (byte_valid) begin
        imm_n   = {byte_data, imm_q[7:0]};
        valid_n = 1'b1;
        nxt     = EXECUTE;
      end
      EXECUTE: begin
        if (exec_done || mcycle_idx == LAST_IDX) nxt = READ_OPCODE;
        else idx_n = mcycle_idx + 3'd1;
      end
      HALTED:  if (wake) nxt = READ_OPCODE;
      LOCKED:  nxt = LOCKED;
      default: nxt = READ_OPCODE;
    endcase
  end

  assign state     = cur;
  assign fetch_req = (cur == READ_OPCODE) || (cur == READ_CB_OPCODE) || (cur == READ_R8) ||
                     (cur == READ_R16_BYTE0) || (cur == READ_R16_BYTE1);
  assign pc_inc    = fetch_req && byte_valid;
  assign timeout   = (cur == EXECUTE) && !exec_done && (mcycle_idx == LAST_IDX);
  assign locked    = (cur == LOCKED);

endmodule

// File: tb/tb_gb_cpu_opcode_sequencer.sv
// Self-checking bench: constant vector table, hand sequences for watchdog/halt/no-CB,
// and random traffic against an instruction-length-table reference model.
module tb_gb_cpu_opcode_sequencer;

  localparam int MAXM = 6;

  logic        clk = 1'b0;
  logic        reset, byte_valid, exec_done, wake;
  logic [7:0]  byte_data;
  logic [2:0]  state, mcycle_idx;
  logic        fetch_req, pc_inc, cb_q, instr_valid, timeout, locked;
  logic [7:0]  opcode_q;
  logic [15:0] imm_q;

  logic        b_bv, b_ed, b_wk;
  logic [7:0]  b_bd;
  logic [2:0]  b_state, b_idx;
  logic        b_fetch, b_pcinc, b_cb, b_iv, b_to, b_locked;
  logic [7:0]  b_op;
  logic [15:0] b_imm;

  int checks = 0;
  int errors = 0;

  gb_cpu_opcode_sequencer #(.MAX_MCYCLES(MAXM), .CB_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .exec_done(exec_done), .wake(wake), .state(state), .fetch_req(fetch_req),
    .pc_inc(pc_inc), .opcode_q(opcode_q), .cb_q(cb_q), .imm_q(imm_q),
    .instr_valid(instr_valid), .mcycle_idx(mcycle_idx), .timeout(timeout), .locked(locked)
  );

  gb_cpu_opcode_sequencer #(.MAX_MCYCLES(MAXM), .CB_ENABLE(1'b0)) dut_nocb (
    .clk(clk), .reset(reset), .byte_valid(b_bv), .byte_data(b_bd),
    .exec_done(b_ed), .wake(b_wk), .state(b_state), .fetch_req(b_fetch),
    .pc_inc(b_pcinc), .opcode_q(b_op), .cb_q(b_cb), .imm_q(b_imm),
    .instr_valid(b_iv), .mcycle_idx(b_idx), .timeout(b_to), .locked(b_locked)
  );

  always #5 clk = ~clk;

  // Reference model: instruction length comes from explicit opcode lists.
  int          len_of [256];
  bit          lock_of[256];
  int          m_state, m_idx;
  logic [7:0]  m_op;
  logic        m_cb, m_iv;
  logic [15:0] m_imm;

  typedef struct {
    logic        rst, bv;
    logic [7:0]  bd;
    logic        ed, wk;
    logic [2:0]  st;
    logic        iv;
    logic [7:0]  op;
    logic        cb;
    logic [15:0] imm;
    logic [2:0]  idx;
    logic        pc;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic buildTables();
    byte unsigned imm8_list[26]  = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                                     8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6,
                                     8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0, 8'hE8,
                                     8'hF8, 8'h10};
    byte unsigned imm16_list[17] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hCA, 8'hD2,
                                     8'hDA, 8'hC3, 8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hCD, 8'hEA,
                                     8'hFA};
    byte unsigned lock_list[11]  = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED,
                                     8'hF4, 8'hFC, 8'hFD};
    for (int i = 0; i < 256; i++) begin
      len_of[i]  = 1;
      lock_of[i] = 1'b0;
    end
    foreach (imm8_list[i])  len_of[imm8_list[i]]  = 2;
    foreach (imm16_list[i]) len_of[imm16_list[i]] = 3;
    foreach (lock_list[i])  lock_of[lock_list[i]] = 1'b1;
  endtask

  task automatic modelReset();
    m_state = 0; m_idx = 0; m_op = 8'h00; m_cb = 1'b0; m_iv = 1'b0; m_imm = 16'h0000;
  endtask

  task automatic modelStep();
    int nst, nidx;
    nst  = m_state;
    nidx = 0;
    m_iv = 1'b0;
    if (reset) begin
      modelReset();
      return;
    end
    case (m_state)
      0: if (byte_valid) begin
        m_op  = byte_data;
        m_cb  = 1'b0;
        m_imm = 16'h0000;
        if (byte_data == 8'hCB)            nst = 1;
        else if (lock_of[byte_data])       nst = 7;
        else if (len_of[byte_data] == 3)   nst = 3;
        else if (len_of[byte_data] == 2)   nst = 2;
        else begin
          nst  = (byte_data == 8'h76) ? 6 : 5;
          m_iv = 1'b1;
        end
      end
      1: if (byte_valid) begin m_op = byte_data; m_cb = 1'b1; m_iv = 1'b1; nst = 5; end
      2: if (byte_valid) begin m_imm = 16'(byte_data); m_iv = 1'b1; nst = 5; end
      3: if (byte_valid) begin m_imm = (m_imm & 16'hFF00) + 16'(byte_data); nst = 4; end
      4: if (byte_valid) begin m_imm = 16'(byte_data) * 16'd256 + (m_imm & 16'h00FF); m_iv = 1'b1; nst = 5; end
      5: if (exec_done || m_idx == MAXM - 1) nst = 0; else nidx = m_idx + 1;
      6: if (wake) nst = 0;
      default: nst = 7;
    endcase
    m_state = nst;
    m_idx   = nidx;
  endtask

  task automatic checkOutput();
    logic exp_fetch, exp_to;
    exp_fetch = (m_state <= 4);
    exp_to    = (m_state == 5) && !exec_done && (m_idx == MAXM - 1);
    chk("state",       16'(state),       16'(m_state));
    chk("fetch_req",   16'(fetch_req),   16'(exp_fetch));
    chk("pc_inc",      16'(pc_inc),      16'(exp_fetch && byte_valid));
    chk("opcode_q",    16'(opcode_q),    16'(m_op));
    chk("cb_q",        16'(cb_q),        16'(m_cb));
    chk("imm_q",       imm_q,            m_imm);
    chk("instr_valid", 16'(instr_valid), 16'(m_iv));
    chk("mcycle_idx",  16'(mcycle_idx),  16'(m_idx));
    chk("timeout",     16'(timeout),     16'(exp_to));
    chk("locked",      16'(locked),      16'(m_state == 7));
  endtask

  task automatic applyStimulus(input logic rst, input logic bv, input logic [7:0] bd,
                               input logic ed, input logic wk);
    reset = rst; byte_valid = bv; byte_data = bd; exec_done = ed; wake = wk;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic endCycle();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic rst, input logic bv, input logic [7:0] bd, input logic ed,
                        input logic wk, input logic [2:0] st, input logic iv, input logic [7:0] op,
                        input logic cb, input logic [15:0] imm, input logic [2:0] idx, input logic pc);
    vec_t v;
    v.rst = rst; v.bv = bv; v.bd = bd; v.ed = ed; v.wk = wk; v.st = st; v.iv = iv;
    v.op = op; v.cb = cb; v.imm = imm; v.idx = idx; v.pc = pc;
    vecs.push_back(v);
  endtask

  initial begin
    buildTables();
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; exec_done = 1'b0; wake = 1'b0;
    b_bv = 1'b0; b_bd = 8'h00; b_ed = 1'b0; b_wk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Two-DUT check: with CB decoding disabled, 0xCB locks up.
    chk("nocb_reset_state", 16'(b_state), 16'd0);
    b_bv = 1'b1; b_bd = 8'hCB;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); endCycle();
    chk("nocb_state", 16'(b_state), 16'd7);
    chk("nocb_locked", 16'(b_locked), 16'd1);
    chk("nocb_iv", 16'(b_iv), 16'd0);
    b_bd = 8'h00;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); endCycle();
    chk("nocb_stays", 16'(b_state), 16'd7);
    b_bv = 1'b0;

    //     rst   bv    bd     ed    wk    st    iv    op     cb    imm        idx   pc
    addVec(1'b0, 1'b1, 8'hFA, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b1);
    addVec(1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 3'd3, 1'b0, 8'hFA, 1'b0, 16'h0000, 3'd0, 1'b1);
    addVec(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 3'd4, 1'b0, 8'hFA, 1'b0, 16'h0034, 3'd0, 1'b1);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 1'b1, 8'hFA, 1'b0, 16'h1234, 3'd0, 1'b0);
    addVec(1'b0, 1'b1, 8'hCB, 1'b1, 1'b0, 3'd0, 1'b0, 8'hFA, 1'b0, 16'h1234, 3'd0, 1'b1);
    addVec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 8'hCB, 1'b0, 16'h0000, 3'd0, 1'b0);
    addVec(1'b0, 1'b1, 8'h7C, 1'b0, 1'b0, 3'd1, 1'b0, 8'hCB, 1'b0, 16'h0000, 3'd0, 1'b1);
    addVec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 1'b1, 8'h7C, 1'b1, 16'h0000, 3'd0, 1'b0);
    addVec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 1'b0, 8'h7C, 1'b1, 16'h0000, 3'd1, 1'b0);
    addVec(1'b0, 1'b1, 8'h76, 1'b0, 1'b0, 3'd0, 1'b0, 8'h7C, 1'b1, 16'h0000, 3'd0, 1'b1);
    addVec(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd6, 1'b1, 8'h76, 1'b0, 16'h0000, 3'd0, 1'b0);
    addVec(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd6, 1'b0, 8'h76, 1'b0, 16'h0000, 3'd0, 1'b0);
    addVec(1'b0, 1'b1, 8'h3E, 1'b0, 1'b0, 3'd0, 1'b0, 8'h76, 1'b0, 16'h0000, 3'd0, 1'b1);
    addVec(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 3'd2, 1'b0, 8'h3E, 1'b0, 16'h0000, 3'd0, 1'b1);
    addVec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 1'b1, 8'h3E, 1'b0, 16'h0055, 3'd0, 1'b0);
    addVec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 1'b0, 8'h3E, 1'b0, 16'h0055, 3'd1, 1'b0);
    addVec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5, 1'b0, 8'h3E, 1'b0, 16'h0055, 3'd2, 1'b0);
    addVec(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b1);
    addVec(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 3'd3, 1'b0, 8'h01, 1'b0, 16'h0000, 3'd0, 1'b1);
    addVec(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 3'd4, 1'b0, 8'h01, 1'b0, 16'h00AA, 3'd0, 1'b1);
    addVec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0);
    addVec(1'b0, 1'b1, 8'hDD, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b1);
    addVec(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 8'hDD, 1'b0, 16'h0000, 3'd0, 1'b0);
    addVec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 8'hDD, 1'b0, 16'h0000, 3'd0, 1'b0);
    addVec(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 16'h0000, 3'd0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].bv, vecs[i].bd, vecs[i].ed, vecs[i].wk);
      chk($sformatf("vec%0d_state", i), 16'(state), 16'(vecs[i].st));
      chk($sformatf("vec%0d_iv", i), 16'(instr_valid), 16'(vecs[i].iv));
      chk($sformatf("vec%0d_op", i), 16'(opcode_q), 16'(vecs[i].op));
      chk($sformatf("vec%0d_cb", i), 16'(cb_q), 16'(vecs[i].cb));
      chk($sformatf("vec%0d_imm", i), imm_q, vecs[i].imm);
      chk($sformatf("vec%0d_idx", i), 16'(mcycle_idx), 16'(vecs[i].idx));
      chk($sformatf("vec%0d_pc", i), 16'(pc_inc), 16'(vecs[i].pc));
      chk($sformatf("vec%0d_locked", i), 16'(locked), 16'(vecs[i].st == 3'd7));
      chk($sformatf("vec%0d_to", i), 16'(timeout), 16'd0);
      endCycle();
    end

    // Watchdog expiry, then exec_done on the limit cycle (no timeout).
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0); endCycle();
    for (int i = 0; i < MAXM; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("wd_state", 16'(state), 16'd5);
      chk("wd_idx", 16'(mcycle_idx), 16'(i));
      chk("wd_timeout", 16'(timeout), 16'(i == MAXM - 1));
      endCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("wd_exit_state", 16'(state), 16'd0);
    endCycle();
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0); endCycle();
    for (int i = 0; i < MAXM; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'(i == MAXM - 1), 1'b0);
      chk("done_idx", 16'(mcycle_idx), 16'(i));
      chk("done_timeout", 16'(timeout), 16'd0);
      endCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("done_exit_state", 16'(state), 16'd0);
    endCycle();

    // HALT ignores bytes and exec_done until wake.
    applyStimulus(1'b0, 1'b1, 8'h76, 1'b0, 1'b0); endCycle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 8'($urandom_range(255)), 1'b1, 1'b0);
      chk("halt_state", 16'(state), 16'd6);
      chk("halt_iv", 16'(instr_valid), 16'(i == 0));
      endCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("halt_wake_state", 16'(state), 16'd6);
    endCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("halt_exit_state", 16'(state), 16'd0);
    endCycle();

    // Random traffic; periodic resets keep LOCKED from absorbing the run.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(1'($urandom_range(63) == 0), 1'($urandom_range(3) != 0),
                    8'($urandom_range(255)), 1'($urandom_range(3) == 0),
                    1'($urandom_range(4) == 0));
      endCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_cpu_opcode_sequencer.md
GB_CPU_OPCODE_SEQUENCER -- requirements
Module: gb_cpu_opcode_sequencer

Interface
REQ-001 Parameter MAX_MCYCLES, default 6, is the execute-phase watchdog limit in M-cycles, legal range 2..8.
REQ-002 Parameter CB_ENABLE, default 1: 1 = 0xCB prefix decoded, 0 = 0xCB treated as hard lock.
REQ-003 Single clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; one rising edge = one M-cycle step.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 byte_valid  in  1  byte_data holds the byte at PC this cycle.
REQ-007 byte_data  in  8  fetched instruction byte.
REQ-008 exec_done  in  1  execute unit finished the current instruction.
REQ-009 wake  in  1  halt release (interrupt pending).
REQ-010 state  out  3  0 READ_OPCODE, 1 READ_CB_OPCODE, 2 READ_R8, 3 READ_R16_BYTE0, 4 READ_R16_BYTE1, 5 EXECUTE, 6 HALTED, 7 LOCKED.
REQ-011 fetch_req  out  1  high in states 0-4.
REQ-012 pc_inc  out  1  fetch_req AND byte_valid, combinational.
REQ-013 opcode_q  out  8  latched primary opcode.
REQ-014 cb_q  out  1  latched instruction is CB-prefixed; opcode_q then holds the CB sub-opcode.
REQ-015 imm_q  out  16  latched immediate.
REQ-016 instr_valid  out  1  one-cycle pulse: instruction fully collected.
REQ-017 mcycle_idx  out  3  execute-phase M-cycle counter.
REQ-018 timeout  out  1  one-cycle pulse: watchdog forced exit.
REQ-019 locked  out  1  high while state == LOCKED.

Function
REQ-020 All state advances only on cycles with byte_valid=1 in states 0-4; with byte_valid=0, state and latches hold.
REQ-021 READ_OPCODE with a valid byte: latch opcode_q, clear cb_q and imm_q, then classify per REQ-022..026.
REQ-022 Two-byte (imm8): 00_xxx110, 0x18, 00_1xx000, 11_xxx110, 0xE0, 0xF0, 0xE8, 0xF8, 0x10 -> READ_R8.
REQ-023 Three-byte (imm16): 00_xx0001, 0x08, 0xC2, 0xCA, 0xD2, 0xDA, 0xC3, 0xC4, 0xCC, 0xD4, 0xDC, 0xCD, 0xEA, 0xFA -> READ_R16_BYTE0.
REQ-024 0xCB -> READ_CB_OPCODE when CB_ENABLE=1; otherwise -> LOCKED.
REQ-025 Hard-lock opcodes D3 DB DD E3 E4 EB EC ED F4 FC FD -> LOCKED, with no instr_valid.
REQ-026 0x76 -> HALTED with instr_valid pulse; every other opcode -> EXECUTE with instr_valid pulse.
REQ-027 READ_CB_OPCODE: latch sub-opcode into opcode_q, set cb_q=1, pulse instr_valid, -> EXECUTE; all 256 sub-opcodes are legal.
REQ-028 READ_R8: imm_q[7:0] = byte, imm_q[15:8] = 0, pulse instr_valid, -> EXECUTE.
REQ-029 READ_R16_BYTE0: imm_q[7:0] = byte, -> READ_R16_BYTE1.
REQ-030 READ_R16_BYTE1: imm_q[15:8] = byte (little-endian), pulse instr_valid, -> EXECUTE.
REQ-031 instr_valid is registered and asserts in the first cycle of EXECUTE or HALTED.
REQ-032 opcode_q, cb_q and imm_q stay stable from instr_valid until the next valid byte in READ_OPCODE.
REQ-033 Latency: 1-, 2-, 3-byte and CB instructions reach EXECUTE 1, 2, 3 and 2 valid-byte cycles after leaving READ_OPCODE.
REQ-034 EXECUTE: mcycle_idx = 0 on entry and increments by 1 each cycle; mcycle_idx is 0 in all other states.
REQ-035 EXECUTE with exec_done=1 -> READ_OPCODE next cycle.
REQ-036 EXECUTE with exec_done=0 and mcycle_idx == MAX_MCYCLES-1 -> READ_OPCODE next cycle with a timeout pulse.
REQ-037 If exec_done=1 and the watchdog limit occur in the same cycle, exec_done wins and there is no timeout.
REQ-038 byte_valid is ignored in EXECUTE, HALTED and LOCKED.
REQ-039 exec_done is ignored outside EXECUTE, and wake is ignored outside HALTED.
REQ-040 HALTED: wake=1 -> READ_OPCODE next cycle; HALTED otherwise.
REQ-041 LOCKED is terminal; only reset exits it.

Reset
REQ-042 reset has priority over all inputs.
REQ-043 Next edge after reset: state = READ_OPCODE, opcode_q = 0, cb_q = 0, imm_q = 0, mcycle_idx = 0, instr_valid = 0, timeout = 0, locked = 0.
REQ-044 Reset asserted mid-fetch or mid-execute discards the partial instruction; the next valid byte is treated as an opcode.

Verification
REQ-045 Bytes 0xFA, 0x34, 0x12 on consecutive valid cycles -> states 0,3,4,5; instr_valid in cycle 4; imm_q = 0x1234; pc_inc high 3 cycles.
REQ-046 Bytes 0xCB, 0x7C with byte_valid low one cycle between them -> READ_CB_OPCODE holds 2 cycles; then cb_q = 1, opcode_q = 0x7C, EXECUTE.
REQ-047 Opcode 0x00, exec_done held low, MAX_MCYCLES = 6 -> mcycle_idx 0..5, timeout pulse at idx 5, then READ_OPCODE; repeat with exec_done at idx 5 -> no timeout.
REQ-048 Opcode 0x76 -> HALTED with instr_valid; stays halted 10 cycles with byte_valid = 1; wake -> READ_OPCODE.
REQ-049 Opcode 0xDD -> LOCKED, locked = 1 and no instr_valid; further bytes ignored; reset -> READ_OPCODE.
REQ-050 CB_ENABLE = 0 with opcode 0xCB -> LOCKED.
REQ-051 Reset asserted in READ_R16_BYTE1 after 0x01, 0xAA -> imm_q = 0 and state 0 next edge.
